norm1_udiv_43ns_4ns_43_seq: RTL and testbench

//   Iterative unsigned divider for the norm1 (LRN) datapath. It undoes a
//   43-bit = 39-bit x 4-bit unsigned product: given a 43-bit dividend and a
//   4-bit divisor, it returns quotient and remainder. Restoring algorithm,
//   one quotient bit per clock, with valid/ready handshakes on both sides.

---
 rtl/norm1_udiv_43ns_4ns_43_seq.sv | 121 ++++++++++++
 tb/tb_norm1_udiv_43ns_4ns_43_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/norm1_udiv_43ns_4ns_43_seq.sv
// Iterative restoring unsigned divider: one quotient bit per clock, MSB first,
// with valid/ready handshakes on the operand and result sides.
module norm1_udiv_43ns_4ns_43_seq #(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 43,
    parameter int DIN1_WIDTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIN0_WIDTH-1:0] quot,
    output logic [DIN1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIN0_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIN0_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DIN0_WIDTH-1:0]   work_r;
    logic [DIN1_WIDTH-1:0]   divisor_r;
    logic [DIN1_WIDTH-1:0]   part_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    dbz_r;

    logic [DIN1_WIDTH:0]     trial_s;
    logic [DIN1_WIDTH-1:0]   next_part_s;
    logic                    qbit_s;

    // One restoring step; the extra trial bit keeps the compare from overflowing.
    always_comb begin
        trial_s     = {part_r, work_r[DIN0_WIDTH-1]};
        next_part_s = trial_s[DIN1_WIDTH-1:0];
        qbit_s      = 1'b0;
        if (trial_s >= {1'b0, divisor_r}) begin
            next_part_s = trial_s[DIN1_WIDTH-1:0] - divisor_r;
            qbit_s      = 1'b1;
        end else begin
            next_part_s = trial_s[DIN1_WIDTH-1:0];
            qbit_s      = 1'b0;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r     <= IDLE;
            work_r      <= {DIN0_WIDTH{1'b0}};
            divisor_r   <= {DIN1_WIDTH{1'b0}};
            part_r      <= {DIN1_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        divisor_r  <= din1;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        if (din1 == {DIN1_WIDTH{1'b0}}) begin
                            work_r      <= {DIN0_WIDTH{1'b1}};
                            part_r      <= din0[DIN1_WIDTH-1:0];
                            dbz_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            work_r  <= din0;
                            part_r  <= {DIN1_WIDTH{1'b0}};
                            dbz_r   <= 1'b0;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    work_r <= {work_r[DIN0_WIDTH-2:0], qbit_s};
                    part_r <= next_part_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_STEP) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quot        = work_r;
    assign rem         = part_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_norm1_udiv_43ns_4ns_43_seq.sv
// Scoreboard bench for the iterative divider: directed cases, back-pressure,
// mid-operation reset and a random soak.
module tb_norm1_udiv_43ns_4ns_43_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [42:0] din0;
    logic [3:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [42:0] quot;
    logic [3:0]  rem;
    logic        div_by_zero;

    typedef struct {
        logic [42:0] a;
        logic [3:0]  b;
        logic [42:0] q;
        logic [3:0]  r;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    norm1_udiv_43ns_4ns_43_seq #(.ID(1), .DIN0_WIDTH(43), .DIN1_WIDTH(4)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din0       (din0),
        .din1       (din1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [42:0] a, input logic [3:0] b, input bit track);
        int    t;
        exp_t  e;
        logic [63:0] junk;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        if (!in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        if (track) begin
            e.a = a;
            e.b = b;
            if (b == 4'd0) begin
                e.q = {43{1'b1}};
                e.r = a[3:0];
                e.z = 1'b1;
            end else begin
                e.q = a / {39'd0, b};
                e.r = 4'(a % {39'd0, b});
                e.z = 1'b0;
            end
            sb_q.push_back(e);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        junk     = {$urandom(), $urandom()};
        din0     = junk[42:0];
        din1     = junk[46:43];
    endtask

    task automatic receive(input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        logic [63:0] prod;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge ap_clk);
            lat++;
        end
        if (!out_valid) begin
            check_val("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        check_val("latency", 64'(lat), 64'(exp_lat));
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check_val("quot", 64'(quot), 64'(e.q));
        check_val("rem", 64'(rem), 64'(e.r));
        check_val("div_by_zero", 64'(div_by_zero), 64'(e.z));
        check_val("in_ready_done", 64'(in_ready), 64'd0);
        if (!e.z) begin
            prod = 64'(quot) * 64'(din1_of(e)) + 64'(rem);
            check_val("identity", prod, 64'(e.a));
            check_val("rem_lt_div", 64'(rem < e.b), 64'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge ap_clk);
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_quot", 64'(quot), 64'(e.q));
            check_val("hold_rem", 64'(rem), 64'(e.r));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
        check_val("valid_drop", 64'(out_valid), 64'd0);
        check_val("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [3:0] din1_of(input exp_t e);
        return e.b;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          seen;
        logic [63:0] rnd;
        logic [42:0] a;
        logic [3:0]  b;

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = 43'd0;
        din1      = 4'd0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_quot", 64'(quot), 64'd0);
        check_val("rst_rem", 64'(rem), 64'd0);
        check_val("rst_dbz", 64'(div_by_zero), 64'd0);

        send(43'd100, 4'd7, 1'b1);          receive(44, 0);
        send({43{1'b1}}, 4'd15, 1'b1);      receive(44, 0);
        send(43'd3, 4'd9, 1'b1);            receive(44, 0);
        send(43'd0, 4'd5, 1'b1);            receive(44, 0);
        send(43'h1234, 4'd0, 1'b1);         receive(1, 0);
        send({43{1'b1}}, 4'd1, 1'b1);       receive(44, 0);
        send({43{1'b1}}, 4'd0, 1'b1);       receive(1, 0);
        send(43'd100, 4'd7, 1'b1);          receive(44, 10);

        // Reset during CALC step 20 must drop the job silently.
        send(43'd12345, 4'd3, 1'b0);
        repeat (20) @(negedge ap_clk);
        check_val("calc_in_ready", 64'(in_ready), 64'd0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_quot", 64'(quot), 64'd0);
        check_val("mid_rst_rem", 64'(rem), 64'd0);
        check_val("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (60) begin
            @(negedge ap_clk);
            if (out_valid) seen++;
        end
        check_val("no_valid_after_rst", 64'(seen), 64'd0);
        send(43'd12, 4'd4, 1'b1);           receive(44, 0);

        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom(), $urandom()};
            a   = rnd[42:0];
            b   = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            send(a, b, 1'b1);
            receive((b == 4'd0) ? 1 : 44, 0);
        end
        check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
